mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  // Refusal counter: counts while requesting and refused, saturates, clears otherwise.
  function automatic logic [WAIT_W-1:0] wait_next(input logic [WAIT_W-1:0] cnt,
                                                  input logic req,
                                                  input logic gnt);
    if (!req || gnt) return '0;
    else if (cnt == WAIT_SAT) return cnt;
    else return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter; slave modport is the arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: starvation override first, then round-robin (MEM_ARB_RR_EN) or data-first priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       i_starve,
  input  logic       d_starve,
`ifdef MEM_ARB_RR_EN
  input  owner_t     last,
`endif
  output logic [1:0] gnt      // {d, i}
);

  always_comb begin
    gnt = 2'b00;
    if (i_req && d_req) begin
      if (d_starve)      gnt = 2'b10;
      else if (i_starve) gnt = 2'b01;
      else begin
`ifdef MEM_ARB_RR_EN
        gnt = (last == OWN_D) ? 2'b01 : 2'b10;
`else
        gnt = 2'b10;
`endif
      end
    end else if (d_req) begin
      gnt = 2'b10;
    end else if (i_req) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data to single-port memory arbiter, one access outstanding, one access per cycle.
// Build option: define MEM_ARB_RR_EN for round-robin; default is data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [15:0]   i_grant_cnt,
  output logic [15:0]   d_grant_cnt
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] i_wait_q, d_wait_q;
  logic [15:0]       i_cnt_q, d_cnt_q;
  logic              i_starve, d_starve;
  logic [1:0]        pick_gnt;
  logic              i_gnt, d_gnt;
`ifdef MEM_ARB_RR_EN
  owner_t            last_q;
`endif

  assign i_starve = (i_wait_q >= MAX_WAIT_C);
  assign d_starve = (d_wait_q >= MAX_WAIT_C);

  mem_arb_pick u_pick (
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .i_starve (i_starve),
    .d_starve (d_starve),
`ifdef MEM_ARB_RR_EN
    .last     (last_q),
`endif
    .gnt      (pick_gnt)
  );

  // Grants are suppressed while reset is held low.
  assign i_gnt = reset & pick_gnt[0];
  assign d_gnt = reset & pick_gnt[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      i_wait_q <= '0;
      d_wait_q <= '0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q   <= OWN_D;
`endif
    end else begin
      state_q  <= state_d;
      i_wait_q <= wait_next(i_wait_q, bus.i_req, i_gnt);
      d_wait_q <= wait_next(d_wait_q, bus.d_req, d_gnt);
      if (i_gnt) i_cnt_q <= i_cnt_q + 16'd1;
      if (d_gnt) d_cnt_q <= d_cnt_q + 16'd1;
`ifdef MEM_ARB_RR_EN
      if (i_gnt || d_gnt) last_q <= d_gnt ? OWN_D : OWN_I;
`endif
    end
  end

  always_comb begin
    state_d       = IDLE;
    bus.i_gnt     = i_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = {DATA_W{1'b0}};
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = {DATA_W{1'b0}};
    // Request stage: drive the memory port for this cycle's winner.
    if (d_gnt) begin
      state_d       = BUSY_D;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      state_d       = BUSY_I;
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.i_addr;
    end
    // Response stage: memory data from last cycle's access returns to its owner.
    if (reset) begin
      case (state_q)
        BUSY_I: begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = bus.mem_rdata;
        end
        BUSY_D: begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grant tracker queues expected responses, monitor checks them.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] i_grant_cnt, d_grant_cnt;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  int          total = 0;
  int          bad   = 0;
  int          i_rv_seen = 0;
  int          d_rv_seen = 0;
  logic [31:0] last_d_rd = '0;
  logic [31:0] ref_mem [1024];
  logic [31:0] store   [1024];
  bit          mem_init;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_d, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((is_d ? bus.d_gnt : bus.i_gnt) === 1'b1) got = 1'b1;
      else tick;
    end
    chk(got, name, 64'(got), 64'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory behind the arbiter: registered read, one cycle after mem_en.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 1024; k++) store[k] <= init_word(32'(k * 4));
      mem_init      <= 1'b1;
      bus.mem_rdata <= 32'h0BAD_0BAD;
    end else if (bus.mem_en) begin
      if (bus.mem_we) store[bus.mem_addr[11:2]] <= bus.mem_wdata;
      bus.mem_rdata <= store[bus.mem_addr[11:2]];
    end else begin
      bus.mem_rdata <= 32'h0BAD_0BAD;
    end
  end

  // Grant tracker: checks the memory port and queues the expected response.
  initial begin
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(32'(k * 4));
    forever begin
      @(negedge clk);
      if (reset !== 1'b1)
        chk(bus.i_gnt === 1'b0 && bus.d_gnt === 1'b0, "gnt_in_reset", {bus.i_gnt, bus.d_gnt}, 0);
      if (bus.i_gnt === 1'b1 && bus.d_gnt === 1'b1) begin
        chk(1'b0, "dual_gnt", 2'b11, 2'b01);
      end else if (bus.d_gnt === 1'b1) begin
        chk(bus.mem_en === 1'b1 && bus.mem_we === bus.d_we && bus.mem_addr === bus.d_addr &&
            (!bus.d_we || bus.mem_wdata === bus.d_wdata),
            "d_mem_port", {bus.mem_we, bus.mem_addr}, {bus.d_we, bus.d_addr});
        if (bus.d_we) begin
          ref_mem[bus.d_addr[11:2]] = bus.d_wdata;
          dq.push_back('{wr: 1'b1, data: 32'h0});
        end else begin
          dq.push_back('{wr: 1'b0, data: ref_mem[bus.d_addr[11:2]]});
        end
      end else if (bus.i_gnt === 1'b1) begin
        chk(bus.mem_en === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === bus.i_addr,
            "i_mem_port", {bus.mem_we, bus.mem_addr}, {1'b0, bus.i_addr});
        iq.push_back('{wr: 1'b0, data: ref_mem[bus.i_addr[11:2]]});
      end else begin
        chk(bus.mem_en === 1'b0 && bus.mem_we === 1'b0 && bus.mem_addr === 32'h0 && bus.mem_wdata === 32'h0,
            "idle_mem_port", {bus.mem_en, bus.mem_we, bus.mem_addr}, 0);
      end
    end
  end

  // Monitor: every rvalid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_rvalid === 1'b1) begin
        i_rv_seen++;
        if (iq.size() == 0) chk(1'b0, "i_rvalid_unexpected", bus.i_rdata, 0);
        else begin
          e = iq.pop_front();
          chk(bus.i_rdata === e.data, "i_rdata", bus.i_rdata, e.data);
        end
      end
      if (bus.d_rvalid === 1'b1) begin
        d_rv_seen++;
        if (dq.size() == 0) chk(1'b0, "d_rvalid_unexpected", bus.d_rdata, 0);
        else begin
          e = dq.pop_front();
          if (e.wr) chk(1'b1, "d_wr_ack", 1, 1);
          else begin
            last_d_rd = bus.d_rdata;
            chk(bus.d_rdata === e.data, "d_rdata", bus.d_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_i, i_hits, missing, base_d;
    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = 32'h0;

    // Reset state with both requesting: no grants, outputs and counters zero.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk(bus.i_gnt === 1'b0 && bus.d_gnt === 1'b0, "rst_gnt", {bus.i_gnt, bus.d_gnt}, 0);
      chk(bus.i_rvalid === 1'b0 && bus.d_rvalid === 1'b0, "rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
      chk(bus.i_rdata === 32'h0 && bus.d_rdata === 32'h0, "rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      chk(i_grant_cnt === 16'h0 && d_grant_cnt === 16'h0, "rst_cnt", {i_grant_cnt, d_grant_cnt}, 0);
    end
    tick;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick;
    reset = 1'b1;

    // Back-to-back fetches from 0x0, 0x4, 0x8.
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(bus.i_gnt === 1'b1, "fetch_gnt", bus.i_gnt, 1);
      chk(bus.i_rvalid === (k != 0), "fetch_rvalid_timing", bus.i_rvalid, (k != 0));
      tick;
      bus.i_addr = 32'(4 * (k + 1));
    end
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    repeat (2) tick;
    @(negedge clk);
    chk(i_rv_seen == 3, "fetch_rvalid_count", i_rv_seen, 3);
    chk(i_grant_cnt === 16'd3 && d_grant_cnt === 16'd0, "fetch_cnt", {i_grant_cnt, d_grant_cnt}, {16'd3, 16'd0});

    // Write 0xDEADBEEF to 0x100, then read it back.
    base_d = d_rv_seen;
    tick;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    wait_gnt(1'b1, "wr_gnt");
    tick;
    bus.d_we = 1'b0; bus.d_wdata = 32'h0;
    wait_gnt(1'b1, "rd_gnt");
    tick;
    bus.d_req = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    chk(d_rv_seen - base_d == 2, "wr_rd_rvalid_count", d_rv_seen - base_d, 2);
    chk(last_d_rd === 32'hDEAD_BEEF, "rd_back", last_d_rd, 32'hDEAD_BEEF);
    chk(d_grant_cnt === 16'd2, "wr_rd_cnt", d_grant_cnt, 2);

    // Both ports contending.
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk(bus.d_gnt === 1'((k % 2) == 1) && bus.i_gnt === 1'((k % 2) == 0), "rr_order",
          {bus.d_gnt, bus.i_gnt}, ((k % 2) == 1) ? 2'b10 : 2'b01);
      tick;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    chk(i_grant_cnt === 16'd6 && d_grant_cnt === 16'd5, "rr_cnt", {i_grant_cnt, d_grant_cnt}, {16'd6, 16'd5});
`else
    first_i = 0; i_hits = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.i_gnt === 1'b1) begin
        i_hits++;
        if (first_i == 0) first_i = c;
      end
      tick;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk(first_i == 5, "starve_first_i", first_i, 5);
    chk(i_hits == 2, "starve_i_hits", i_hits, 2);
    repeat (2) tick;
    @(negedge clk);
    chk(i_grant_cnt === 16'd5 && d_grant_cnt === 16'd10, "fp_cnt", {i_grant_cnt, d_grant_cnt}, {16'd5, 16'd10});
`endif

    // Reset while a data read is outstanding.
    tick;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
    wait_gnt(1'b1, "rst_rd_gnt");
    tick;
    reset = 1'b0; bus.d_req = 1'b0;
    iq.delete(); dq.delete();
    @(negedge clk);
    chk({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we} === 6'b0,
        "midrst_ctrl", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we}, 0);
    chk(bus.mem_addr === 32'h0 && bus.mem_wdata === 32'h0, "midrst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
    chk(bus.i_rdata === 32'h0 && bus.d_rdata === 32'h0, "midrst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    tick;
    @(negedge clk);
    chk(i_grant_cnt === 16'h0 && d_grant_cnt === 16'h0, "midrst_cnt", {i_grant_cnt, d_grant_cnt}, 0);
    tick;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(bus.d_rvalid === 1'b0, "post_rst_no_rvalid", bus.d_rvalid, 0);
      tick;
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'h40;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    chk(bus.i_gnt === 1'b1 && bus.d_gnt === 1'b0, "post_rst_winner", {bus.d_gnt, bus.i_gnt}, 2'b01);
`else
    chk(bus.d_gnt === 1'b1 && bus.i_gnt === 1'b0, "post_rst_winner", {bus.d_gnt, bus.i_gnt}, 2'b10);
`endif
    tick;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) tick;

    // 65536 fetch grants from a fresh reset wrap the counter back to 0.
    reset = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    missing = 0;
    for (int n = 1; n <= 65536; n++) begin
      @(negedge clk);
      if (bus.i_gnt !== 1'b1) missing++;
      if (n == 65536) chk(i_grant_cnt === 16'hFFFF, "wrap_ffff", i_grant_cnt, 16'hFFFF);
      tick;
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    chk(missing == 0, "wrap_missing_gnts", missing, 0);
    chk(i_grant_cnt === 16'h0, "wrap_zero", i_grant_cnt, 0);

    repeat (3) tick;
    @(negedge clk);
    chk(iq.size() == 0 && dq.size() == 0, "queues_drained", iq.size() + dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
